// File: rtl/mfcc_feat_collector_pkg.sv
// Shared definitions for the MFCC feature collector: frame geometry, read FSM states
// and the ping-pong buffer index type.
package mfcc_feat_collector_pkg;

  localparam int N_FEAT = 13;
  localparam int DW     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

  typedef logic buf_idx_t;

endpackage

// File: rtl/mfcc_feat_frame_buf.sv
// One frame of feature storage: synchronous write port and asynchronous read port.
// Contents have no reset; a frame is always fully rewritten before it is read.
module mfcc_feat_frame_buf
  import mfcc_feat_collector_pkg::*;
#(
  parameter int N  = N_FEAT,
  parameter int W  = DW,
  parameter int IW = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [W-1:0]  wdata,
  input  logic [IW-1:0] ridx,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/mfcc_feat_collector.sv
// Collects contiguous feature bursts into a two-frame ping-pong buffer, checks frame length
// and replays frames on a valid/ready stream. Optional MFCC_DROP_C0_EN drops coefficient 0.
module mfcc_feat_collector #(
  parameter int N_FEAT = mfcc_feat_collector_pkg::N_FEAT,
  parameter int DW     = mfcc_feat_collector_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tvalid_dct2_feat,
  input  logic [DW-1:0] dct2_feat,
  output logic          m_tvalid,
  output logic [DW-1:0] m_tdata,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic          err_len,
  output logic          err_ovf
);
  import mfcc_feat_collector_pkg::*;

  localparam int IW = $clog2(N_FEAT + 2);
  localparam logic [IW-1:0] LEN_IDX  = IW'(N_FEAT);
  localparam logic [IW-1:0] SAT_IDX  = IW'(N_FEAT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_FEAT - 1);
`ifdef MFCC_DROP_C0_EN
  localparam logic [IW-1:0] FIRST_IDX = IW'(1);
`else
  localparam logic [IW-1:0] FIRST_IDX = '0;
`endif

  logic          tv_q, tv_d;
  logic          wr_act_q, wr_act_d;
  buf_idx_t      wr_buf_q, wr_buf_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]    full_q, full_d;
  buf_idx_t      oldest_q, oldest_d;
  logic          err_len_q, err_len_d;
  logic          err_ovf_q, err_ovf_d;
  rd_state_e     state_q, state_d;
  buf_idx_t      rd_buf_q, rd_buf_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;

  logic          hs, rd_last, burst_start, burst_end, start_ok, len_ok, keep_idx, wr_en;
  logic [1:0]    rel_mask, set_mask, free, avail, we;
  buf_idx_t      start_buf, cur_buf, other_wr, other_rd;
  logic [IW-1:0] cur_idx;
  logic [DW-1:0] rdata0, rdata1;

  // Write control, full/age flags and error pulses
  always_comb begin
    hs          = (state_q == SEND) && m_tready;
    rd_last     = (rd_idx_q == LAST_IDX);
    rel_mask    = '0;
    if (hs && rd_last) rel_mask[rd_buf_q] = 1'b1;
    free        = ~full_q | rel_mask;
    burst_start = tvalid_dct2_feat && !tv_q;
    burst_end   = !tvalid_dct2_feat && wr_act_q;
    start_ok    = |free;
    start_buf   = free[0] ? 1'b0 : 1'b1;
    len_ok      = (wr_idx_q == LEN_IDX);
    set_mask    = '0;
    if (burst_end && len_ok) set_mask[wr_buf_q] = 1'b1;
    cur_idx     = burst_start ? '0 : wr_idx_q;
    cur_buf     = burst_start ? start_buf : wr_buf_q;
`ifdef MFCC_DROP_C0_EN
    keep_idx    = (cur_idx != '0);
`else
    keep_idx    = 1'b1;
`endif
    wr_en       = tvalid_dct2_feat && (burst_start ? start_ok : wr_act_q) &&
                  (cur_idx < LEN_IDX) && keep_idx;
    we          = {wr_en && cur_buf, wr_en && !cur_buf};

    tv_d      = tvalid_dct2_feat;
    wr_act_d  = wr_act_q;
    wr_buf_d  = wr_buf_q;
    wr_idx_d  = wr_idx_q;
    err_len_d = 1'b0;
    err_ovf_d = 1'b0;
    if (burst_start) begin
      wr_act_d  = start_ok;
      wr_buf_d  = start_buf;
      wr_idx_d  = start_ok ? IW'(1) : '0;
      err_ovf_d = !start_ok;
    end else if (tvalid_dct2_feat && wr_act_q) begin
      wr_idx_d  = (wr_idx_q == SAT_IDX) ? SAT_IDX : wr_idx_q + IW'(1);
    end else if (burst_end) begin
      wr_act_d  = 1'b0;
      wr_idx_d  = '0;
      err_len_d = !len_ok;
    end

    full_d   = (full_q & ~rel_mask) | set_mask;
    other_wr = ~wr_buf_q;
    oldest_d = oldest_q;
    if (|set_mask) oldest_d = full_d[other_wr] ? other_wr : wr_buf_q;
  end

  // Read FSM. A frame completing this cycle is visible immediately so the first
  // word appears the cycle after the burst ends, and back-to-back frames have no bubble.
  always_comb begin
    state_d  = state_q;
    rd_buf_d = rd_buf_q;
    rd_idx_d = rd_idx_q;
    avail    = full_q | set_mask;
    other_rd = ~rd_buf_q;
    case (state_q)
      IDLE: begin
        if (|avail) begin
          state_d  = SEND;
          rd_idx_d = FIRST_IDX;
          if (full_q == 2'b11)     rd_buf_d = oldest_q;
          else if (full_q != 2'b00) rd_buf_d = full_q[1];
          else                      rd_buf_d = set_mask[1];
        end
      end
      SEND: begin
        if (hs) begin
          if (rd_last) begin
            rd_idx_d = FIRST_IDX;
            if (avail[other_rd]) rd_buf_d = other_rd;
            else                 state_d  = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tv_q      <= 1'b0;
      wr_act_q  <= 1'b0;
      wr_buf_q  <= 1'b0;
      wr_idx_q  <= '0;
      full_q    <= '0;
      oldest_q  <= 1'b0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
      state_q   <= IDLE;
      rd_buf_q  <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      tv_q      <= tv_d;
      wr_act_q  <= wr_act_d;
      wr_buf_q  <= wr_buf_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
      oldest_q  <= oldest_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
      state_q   <= state_d;
      rd_buf_q  <= rd_buf_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  mfcc_feat_frame_buf #(.N(N_FEAT), .W(DW), .IW(IW)) u_buf0 (
    .clk   (clk),
    .we    (we[0]),
    .widx  (cur_idx),
    .wdata (dct2_feat),
    .ridx  (rd_idx_q),
    .rdata (rdata0)
  );

  mfcc_feat_frame_buf #(.N(N_FEAT), .W(DW), .IW(IW)) u_buf1 (
    .clk   (clk),
    .we    (we[1]),
    .widx  (cur_idx),
    .wdata (dct2_feat),
    .ridx  (rd_idx_q),
    .rdata (rdata1)
  );

  assign m_tvalid = (state_q == SEND);
  assign m_tdata  = m_tvalid ? (rd_buf_q ? rdata1 : rdata0) : '0;
  assign m_tlast  = m_tvalid && rd_last;
  assign err_len  = err_len_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: doc/mfcc_feat_collector.md
# mfcc_feat_collector

Receiver for the scaled DCT-II feature burst: it collects the float32 MFCC coefficients that arrive on a contiguous valid burst and checks each frame's length. Complete frames are held in a two-frame ping-pong buffer. Each held frame is then re-emitted to the VAD classifier over a valid/ready stream with an end-of-frame marker. It sits directly after the DCT-II coefficient scaling stage and absorbs classifier back-pressure, which the upstream MFCC pipeline cannot accept.

## Interface
Parameters:
- N_FEAT, 13, number of coefficients per frame (burst length accepted as a frame)
- DW, 32, sample width (IEEE-754 single, passed through untouched)

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  reset, synchronous, active-low
- tvalid_dct2_feat  in  1  high for each cycle of a feature burst; a frame is one contiguous high run
- dct2_feat  in  DW  feature sample, valid when tvalid_dct2_feat=1
- m_tvalid  out  1  output word valid
- m_tdata  out  DW  output feature
- m_tlast  out  1  high on the last word of a frame
- m_tready  in  1  downstream accept
- err_len  out  1  one-cycle pulse: burst discarded because its length was not the expected length
- err_ovf  out  1  one-cycle pulse: burst dropped because both buffers were occupied

## Operation
Write side:
- A burst starts on a 0→1 transition of tvalid_dct2_feat.
- At burst start, a free buffer is selected (lower index first). A buffer freed by the final read handshake in the same cycle counts as free.
- If no buffer is free, the whole burst is ignored. err_ovf pulses on the cycle after burst start.
- wr_idx counts samples from 0. Samples with wr_idx<N_FEAT are written. wr_idx saturates at N_FEAT+1.
- The burst ends on the first cycle that tvalid_dct2_feat=0 is sampled (cycle E).
- If exactly N_FEAT samples were received, the buffer is marked full at the end of cycle E and its age order is recorded.
- Otherwise the buffer stays free and err_len pulses in cycle E+1.
- Buffer contents are never cleared, only overwritten.

Read side FSM:
- IDLE: if any buffer is full, select the oldest, set rd_idx=0, go to SEND.
- SEND: m_tvalid=1 and m_tdata=buf[rd_buf][rd_idx]. m_tlast=1 when rd_idx=N_FEAT-1 (or the last kept index; see Configuration).
- On m_tvalid&&m_tready, rd_idx increments.
- On a handshake with m_tlast=1, the buffer is freed. The FSM then selects the other buffer if it is full, staying in SEND with no bubble; otherwise it goes to IDLE.
- Without a handshake, m_tdata, m_tlast and rd_idx hold.

Reset:
- Both buffers are marked free.
- FSM goes to IDLE; wr_idx=0; burst tracking is cleared.
- m_tvalid=0, m_tlast=0, err_len=0, err_ovf=0, m_tdata=0.
- A burst in progress at reset is lost. If tvalid_dct2_feat is high on the first cycle after reset, that run is treated as a new burst start.

## Timing
- Latency from burst end to output: the last sample is at cycle E-1, the buffer is full at the end of E, and m_tvalid=1 at E+1 when the FSM is idle.
- The first word is presented at E+1. Later words need one handshake per cycle; throughput is one word per cycle with m_tready held high.
- Back-to-back bursts need at least one tvalid-low cycle between them. Up to two frames can be pending while a third is refused.
- All outputs are registered except that m_tdata/m_tlast are selected by registered rd_buf/rd_idx.

## Configuration
- MFCC_DROP_C0_EN defined:
  - Coefficient 0 (the energy term) is not written to the buffer.
  - Output frames have N_FEAT-1 words. m_tlast is on index N_FEAT-1, and output indices run 1..N_FEAT-1.
  - The length check still expects N_FEAT input samples.
- MFCC_DROP_C0_EN undefined: all N_FEAT coefficients are forwarded.

## Structure
- Shared MFCC package:
  - N_FEAT, DW
  - read-FSM state enumeration (IDLE, SEND)
  - the buffer-index type
- One sub-module, mfcc_feat_frame_buf: a single N_FEAT×DW register-file frame with a write port (we, widx, wdata) and an asynchronous read port, instantiated twice.
- The top contains the write control, the age/full flags, the read FSM and the error pulses.

## Test plan
1. Single frame: burst of 13 samples 0x3F800000..0x3F80000C, m_tready=1 → 13 words in order from E+1, m_tlast only on word 13, no error pulses.
2. Back-pressure: same frame with m_tready toggling 1,0,0,1… → no word lost or repeated, and m_tdata stable while stalled.
3. Length error: bursts of 12 and then 14 samples → err_len pulses at E+1 of each burst, m_tvalid never rises, and a following 13-sample burst is output normally.
4. Overflow: three 13-sample bursts separated by 1 low cycle, with m_tready=0 → frames 1 and 2 are retained, err_ovf pulses for frame 3, and releasing m_tready outputs frame 1 then frame 2 with no bubble.
5. Reset mid-burst: rst=0 after 6 samples, then a 13-sample burst → only the new frame is output and all outputs are 0 during reset.
6. MFCC_DROP_C0_EN build: scenario 1 repeated → 12 words 0x3F800001..0x3F80000C, with m_tlast on 0x3F80000C.
